// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data-cache controller.
// Tag/valid/dirty/data arrays are internal; stalls the core until each access completes.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for cpu_req; request fields latched on acceptance
// COMPARE   | tag lookup; hit completes the access, miss starts a refill
// WRITEBACK | dirty victim line being written to memory
// ALLOCATE  | requested line being fetched from memory
module dcache_ctrl #(
  parameter int LINES = 8,
  parameter int IDX_W = $clog2(LINES)
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         cpu_req,
  input  logic         cpu_we,
  input  logic [31:0]  cpu_addr,
  input  logic [31:0]  cpu_wdata,
  input  logic [3:0]   cpu_be,
  output logic [31:0]  cpu_rdata,
  output logic         cpu_ready,
  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ack,
  output logic [31:0]  hit_cnt,
  output logic [31:0]  miss_cnt,
  output logic [31:0]  wb_cnt
);

  localparam int TAG_W = 32 - 4 - IDX_W;

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;

  state_t state_q, state_d;

  logic [31:2]      req_addr_q;
  logic             req_we_q;
  logic [31:0]      req_wdata_q;
  logic [3:0]       req_be_q;
  logic             retry_q;

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [127:0]     data_q [LINES];

  logic [31:0]      hit_cnt_q, miss_cnt_q, wb_cnt_q;

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [1:0]       req_off;
  logic [127:0]     cur_line;
  logic [TAG_W-1:0] cur_tag;
  logic             hit;
  logic [31:0]      rd_word;
  logic [127:0]     merged_line;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^cpu_addr[1:0];

  assign req_idx  = req_addr_q[4 +: IDX_W];
  assign req_tag  = req_addr_q[31 -: TAG_W];
  assign req_off  = req_addr_q[3:2];
  assign cur_line = data_q[req_idx];
  assign cur_tag  = tag_q[req_idx];
  assign hit      = valid_q[req_idx] && (cur_tag == req_tag);
  assign rd_word  = cur_line[{req_off, 5'd0} +: 32];

  // Store data merged into the resident line, only bytes with be=1 replaced.
  always_comb begin
    merged_line = cur_line;
    for (int w = 0; w < 4; w++) begin
      for (int b = 0; b < 4; b++) begin
        if (req_off == 2'(w) && req_be_q[b]) begin
          merged_line[w*32 + b*8 +: 8] = req_wdata_q[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (cpu_req) state_d = COMPARE;
      COMPARE: begin
        if (hit)                                  state_d = IDLE;
        else if (valid_q[req_idx] && dirty_q[req_idx]) state_d = WRITEBACK;
        else                                      state_d = ALLOCATE;
      end
      WRITEBACK: if (mem_ack) state_d = ALLOCATE;
      ALLOCATE:  if (mem_ack) state_d = COMPARE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    cpu_ready = 1'b0;
    cpu_rdata = 32'd0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 128'd0;
    case (state_q)
      COMPARE: begin
        if (hit) begin
          cpu_ready = 1'b1;
          cpu_rdata = req_we_q ? 32'd0 : rd_word;
        end
      end
      WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {cur_tag, req_idx, 4'b0000};
        mem_wdata = cur_line;
      end
      ALLOCATE: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag, req_idx, 4'b0000};
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      req_addr_q  <= '0;
      req_we_q    <= 1'b0;
      req_wdata_q <= 32'd0;
      req_be_q    <= 4'd0;
    end else if (state_q == IDLE && cpu_req) begin
      req_addr_q  <= cpu_addr[31:2];
      req_we_q    <= cpu_we;
      req_wdata_q <= cpu_wdata;
      req_be_q    <= cpu_be;
    end
  end

  // The retry after a refill is a guaranteed hit and must not count as one.
  always_ff @(posedge CLK) begin
    if (RST)                                  retry_q <= 1'b0;
    else if (state_q == ALLOCATE && mem_ack)  retry_q <= 1'b1;
    else if (state_q == COMPARE)              retry_q <= 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (state_q == COMPARE && hit && req_we_q) dirty_q[req_idx] <= 1'b1;
      if (state_q == WRITEBACK && mem_ack)       dirty_q[req_idx] <= 1'b0;
      if (state_q == ALLOCATE && mem_ack) begin
        valid_q[req_idx] <= 1'b1;
        dirty_q[req_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (state_q == ALLOCATE && mem_ack) begin
      tag_q[req_idx]  <= req_tag;
      data_q[req_idx] <= mem_rdata;
    end else if (state_q == COMPARE && hit && req_we_q) begin
      data_q[req_idx] <= merged_line;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
      wb_cnt_q   <= 32'd0;
    end else begin
      if (state_q == COMPARE && hit && !retry_q) hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (state_q == COMPARE && !hit)            miss_cnt_q <= miss_cnt_q + 32'd1;
      if (state_q == WRITEBACK && mem_ack)       wb_cnt_q   <= wb_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
  assign wb_cnt   = wb_cnt_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: hit, clean/dirty miss, stalls, store merge and reset.
module tb_dcache_ctrl;

  logic         CLK;
  logic         RST;
  logic         cpu_req;
  logic         cpu_we;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic [3:0]   cpu_be;
  logic [31:0]  cpu_rdata;
  logic         cpu_ready;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ack;
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;
  logic [31:0]  wb_cnt;

  int checks   = 0;
  int failures = 0;

  dcache_ctrl #(.LINES(8)) dut (
    .CLK(CLK), .RST(RST),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present one request in IDLE; on return the DUT is in COMPARE.
  task automatic issue(input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cpu_be    = be;
    tick();
    cpu_req   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0;
    cpu_wdata = 32'd0; cpu_be = 4'd0; mem_rdata = 128'd0; mem_ack = 1'b0;
    tick(); tick();
    RST = 1'b0;

    check("rst_ready", cpu_ready, 0);
    check("rst_rdata", cpu_rdata, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_cnts", {hit_cnt, miss_cnt, wb_cnt}, 0);

    // Clean miss on 0x10
    issue(1'b0, 32'h10, 32'd0, 4'd0);
    check("t1_cmp_ready", cpu_ready, 0);
    tick();
    check("t1_mem_req", mem_req, 1);
    check("t1_mem_we", mem_we, 0);
    check("t1_mem_addr", mem_addr, 32'h10);
    check("t1_miss", miss_cnt, 1);
    mem_rdata = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("t1_ready", cpu_ready, 1);
    check("t1_rdata", cpu_rdata, 32'hAAAAAAAA);
    check("t1_req_drop", mem_req, 0);
    tick();
    check("t1_ready_pulse", cpu_ready, 0);
    check("t1_hit", hit_cnt, 0);

    // Load hit
    issue(1'b0, 32'h14, 32'd0, 4'd0);
    check("t2_ready", cpu_ready, 1);
    check("t2_rdata", cpu_rdata, 32'hBBBBBBBB);
    check("t2_mem_req", mem_req, 0);
    tick();
    check("t2_hit", hit_cnt, 1);

    // Store hit with partial byte enables
    issue(1'b1, 32'h18, 32'h12345678, 4'b0011);
    check("t3_st_ready", cpu_ready, 1);
    check("t3_st_rdata", cpu_rdata, 0);
    tick();
    check("t3_hit", hit_cnt, 2);
    issue(1'b0, 32'h18, 32'd0, 4'd0);
    check("t3_ld_ready", cpu_ready, 1);
    check("t3_ld_rdata", cpu_rdata, 32'hCCCC5678);
    tick();
    check("t3_hit2", hit_cnt, 3);

    // Aliasing dirty miss with a slow writeback ack
    issue(1'b0, 32'h98, 32'd0, 4'd0);
    check("t4_cmp_ready", cpu_ready, 0);
    tick();
    check("t4_wb_req", mem_req, 1);
    check("t4_wb_we", mem_we, 1);
    check("t4_wb_addr", mem_addr, 32'h10);
    check("t4_wb_word2", mem_wdata[95:64], 32'hCCCC5678);
    check("t4_wb_line", mem_wdata,
          {32'hDDDDDDDD, 32'hCCCC5678, 32'hBBBBBBBB, 32'hAAAAAAAA});
    check("t4_miss", miss_cnt, 2);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5_hold", {mem_req, mem_we, mem_addr}, {1'b1, 1'b1, 32'h10});
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("t4_al_req", mem_req, 1);
    check("t4_al_we", mem_we, 0);
    check("t4_al_addr", mem_addr, 32'h90);
    check("t4_wb_cnt", wb_cnt, 1);
    check("t4_miss2", miss_cnt, 2);
    mem_rdata = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("t4_ready", cpu_ready, 1);
    check("t4_rdata", cpu_rdata, 32'h33333333);
    tick();
    check("t4_retry_nohit", hit_cnt, 3);
    issue(1'b0, 32'h94, 32'd0, 4'd0);
    check("t4_hit_rdata", {cpu_ready, cpu_rdata}, {1'b1, 32'h22222222});
    tick();
    check("t4_hit", hit_cnt, 4);

    // Stray ack in IDLE
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("t5_stray_req", mem_req, 0);
    check("t5_stray_ready", cpu_ready, 0);
    check("t5_stray_cnts", {hit_cnt, miss_cnt, wb_cnt}, {32'd4, 32'd2, 32'd1});
    tick();
    check("t5_stray_req2", mem_req, 0);

    // Store miss: allocate, ack in the same cycle mem_req rises, merge on retry
    issue(1'b1, 32'h2C, 32'hDEADBEEF, 4'b1111);
    check("sm_cmp_ready", cpu_ready, 0);
    tick();
    check("sm_al_addr", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'h20});
    check("sm_miss", miss_cnt, 3);
    mem_rdata = {4{32'h55555555}};
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("sm_ready", cpu_ready, 1);
    check("sm_rdata", cpu_rdata, 0);
    tick();
    check("sm_retry_nohit", hit_cnt, 4);
    issue(1'b0, 32'h2C, 32'd0, 4'd0);
    check("sm_ld", {cpu_ready, cpu_rdata}, {1'b1, 32'hDEADBEEF});
    tick();
    check("sm_hit", hit_cnt, 5);

    // Evict the store-miss line: it must be dirty
    issue(1'b0, 32'hAC, 32'd0, 4'd0);
    tick();
    check("ev_wb", {mem_req, mem_we, mem_addr}, {1'b1, 1'b1, 32'h20});
    check("ev_wdata", mem_wdata, {32'hDEADBEEF, {3{32'h55555555}}});
    check("ev_miss", miss_cnt, 4);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("ev_al", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'hA0});
    check("ev_wb_cnt", wb_cnt, 2);

    // Reset while ALLOCATE waits for ack
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("t6_mem_req", mem_req, 0);
    check("t6_ready", cpu_ready, 0);
    check("t6_cnts", {hit_cnt, miss_cnt, wb_cnt}, 0);
    check("t6_mem_addr", mem_addr, 0);
    issue(1'b0, 32'h14, 32'd0, 4'd0);
    check("t6_cmp_ready", cpu_ready, 0);
    tick();
    check("t6_al", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'h10});
    check("t6_miss", miss_cnt, 1);
    mem_rdata = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("t6_rd", {cpu_ready, cpu_rdata}, {1'b1, 32'hBBBBBBBB});
    tick();

    // Topmost line of the address space
    issue(1'b0, 32'hFFFFFFFC, 32'd0, 4'd0);
    tick();
    check("top_al", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'hFFFFFFF0});
    check("top_miss", miss_cnt, 2);
    mem_rdata = {32'h87654321, 32'h0BADF00D, 32'h01234567, 32'h89ABCDEF};
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("top_rd", {cpu_ready, cpu_rdata}, {1'b1, 32'h87654321});
    tick();
    check("top_cnts", {hit_cnt, wb_cnt}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data-cache controller between the multicycle RISC-V core's load/store path and main memory.
- Holds the tag, valid, dirty and data arrays internally.
- Sequences hit, miss, eviction and refill.
- Stalls the core's MEM states until the access completes.

Parameters:
- LINES, 8, number of cache lines (power of 2, ≥2); line = 4 words = 16 bytes.
- IDX_W, $clog2(LINES), index width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous active-high reset.
- cpu_req  in  1  access request from core.
- cpu_we  in  1  1=store, 0=load.
- cpu_addr  in  32  byte address; bits [1:0] ignored.
- cpu_wdata  in  32  store data.
- cpu_be  in  4  store byte enables (bit i → byte i).
- cpu_rdata  out  32  load data; valid only while cpu_ready=1.
- cpu_ready  out  1  one-cycle completion pulse.
- mem_req  out  1  memory line request.
- mem_we  out  1  1=line writeback, 0=line fetch.
- mem_addr  out  32  line-aligned address, bits [3:0]=0.
- mem_wdata  out  128  writeback line; word w at [32w+31:32w].
- mem_rdata  in  128  refill line, same packing.
- mem_ack  in  1  one-cycle completion from memory.
- hit_cnt  out  32  hit counter.
- miss_cnt  out  32  miss counter.
- wb_cnt  out  32  dirty-writeback counter.

Behaviour:
- **Reset and interface rules**
  - Reset: synchronous, active-high, taken at the clock edge where RST=1.
  - Reset values: state=IDLE; all valid=0, dirty=0; cpu_ready=0, cpu_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; hit_cnt, miss_cnt, wb_cnt = 0.
  - Data and tag arrays are not reset.
  - Reset wins over every other event. Reset mid-miss drops mem_req the next cycle and abandons the transaction; dirty data is lost by design.
  - Address split: offset=addr[3:2], index=addr[4+IDX_W-1:4], tag=addr[31:4+IDX_W].
- **States**
  - **IDLE**
    - If cpu_req=1: latch addr/we/wdata/be into request registers, go to COMPARE.
    - Core inputs are ignored in every other state.
  - **COMPARE** (hit: valid[idx] && tag match)
    - Load hit: cpu_rdata = word[offset], cpu_ready=1.
    - Store hit: merge bytes where be=1, set dirty[idx]=1, cpu_ready=1, cpu_rdata=0.
    - On a hit: hit_cnt++ unless this COMPARE is the retry after a refill. Go to IDLE.
    - Miss: miss_cnt++. Go to WRITEBACK if valid && dirty, else to ALLOCATE.
  - **WRITEBACK**
    - mem_req=1, mem_we=1, mem_addr={stored tag, idx, 4'b0}, mem_wdata=stored line.
    - Outputs are held stable until mem_ack=1.
    - On ack: wb_cnt++, clear dirty[idx], go to ALLOCATE.
  - **ALLOCATE**
    - mem_req=1, mem_we=0, mem_addr={req tag, idx, 4'b0}.
    - On ack: write mem_rdata to the line, tag=req tag, valid=1, dirty=0, go to COMPARE (retry, guaranteed hit).
- **Latency**
  - Hit: request sampled in IDLE at cycle N → cpu_ready at N+1.
  - Clean miss: mem_req from N+2; cpu_ready one cycle after the refill ack.
  - Dirty miss: adds a full writeback transaction before the refill.
- **Handshakes**
  - cpu_ready is high for exactly one cycle per request.
  - A new request may be presented in the IDLE cycle directly after cpu_ready; the core must deassert cpu_req after cpu_ready unless it is issuing a new access.
  - mem_req deasserts in the cycle after mem_ack.
  - mem_ack while mem_req=0 is ignored.
  - mem_ack in the same cycle mem_req first rises is legal and accepted.
- **Arithmetic**
  - Counters wrap modulo 2^32.
  - The retry hit in COMPARE does not increment hit_cnt. A one-bit retry flag, set on refill ack and cleared on leaving COMPARE, implements this.
- **Boundaries**
  - Index aliasing (same idx, different tag) always evicts.
  - A store miss allocates, then merges on retry, leaving the line dirty.
  - The address 0xFFFF_FFF0 line is legal.

Test Plan:
1. Reset, load 0x0000_0010 → mem_req=1, mem_we=0, mem_addr=0x10. Memory acks with line {0xDDDDDDDD,0xCCCCCCCC,0xBBBBBBBB,0xAAAAAAAA}; one cycle later cpu_ready=1, cpu_rdata=0xAAAAAAAA; miss_cnt=1, hit_cnt=0.
2. Load 0x14 immediately after → cpu_ready on the next cycle with cpu_rdata=0xBBBBBBBB; mem_req stays 0; hit_cnt=1.
3. Store 0x18, be=4'b0011, wdata=0x12345678 → hit, ready after 1 cycle. A subsequent load of 0x18 returns 0xCCCC5678.
4. Load 0x98 (same index, tag 1, LINES=8) → first mem_req with mem_we=1, mem_addr=0x10, word2 of mem_wdata=0xCCCC5678. After its ack, mem_req with mem_we=0, mem_addr=0x90; wb_cnt=1, miss_cnt=2.
5. Memory delays ack by 5 cycles → mem_req/mem_addr/mem_we held constant for all 5 cycles. A stray mem_ack pulse while in IDLE changes nothing.
6. RST=1 for one cycle while ALLOCATE waits for ack → next cycle mem_req=0, cpu_ready=0, all counters 0. A following load of 0x14 misses (mem_addr=0x10).
